// File: rtl/dmem_sram_bridge.sv
// MEM-stage data RAM responder that serves 32-bit byte-lane requests on an
// external 8-bit asynchronous SRAM, one byte per access, stalling the pipeline meanwhile.
module dmem_sram_bridge #(
  parameter int SRAM_AW = 20,
  parameter int RD_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               stallreq_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [7:0]         sram_dq_o,
  output logic               sram_dq_oe_o,
  input  logic [7:0]         sram_dq_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WS   = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] RD_LAST = 3'(RD_WAIT);

  logic [2:0]         state_q, state_d;
  logic               we_q, we_d;
  logic [SRAM_AW-3:0] addr_q, addr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        asm_q, asm_d;
  logic [SRAM_AW-1:0] sramAddr_q, sramAddr_d;
  logic [7:0]         dqOut_q, dqOut_d;
  logic               dqOe_q, dqOe_d;
  logic               ceN_q, ceN_d;
  logic               oeN_q, oeN_d;
  logic               weN_q, weN_d;
  logic [31:0]        dataOut_q, dataOut_d;

  logic [3:0] rest;
  logic [1:0] nextLane;
  logic [1:0] startLane;
  logic       unused_addr;

  function automatic logic [1:0] hiLane(input logic [3:0] s);
    if (s[3])      return 2'd3;
    else if (s[2]) return 2'd2;
    else if (s[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [7:0] laneByte(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

  assign unused_addr = ^{addr_i[31:SRAM_AW], addr_i[1:0]};

  assign stallreq_o   = ce_i && (sel_i != 4'b0000) && (state_q != S_DONE);
  assign data_o       = dataOut_q;
  assign sram_addr_o  = sramAddr_q;
  assign sram_dq_o    = dqOut_q;
  assign sram_dq_oe_o = dqOe_q;
  assign sram_ce_n_o  = ceN_q;
  assign sram_oe_n_o  = oeN_q;
  assign sram_we_n_o  = weN_q;

  // SRAM pin values are computed for the state being entered, so they are
  // registered alongside the state and never glitch. Lane L sits at offset 3-L (= ~L).
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    sramAddr_d = sramAddr_q;
    dqOut_d    = dqOut_q;
    dqOe_d     = 1'b0;
    ceN_d      = 1'b1;
    oeN_d      = 1'b1;
    weN_d      = 1'b1;
    dataOut_d  = 32'h0;
    rest       = sel_q & ~(4'b0001 << lane_q);
    nextLane   = hiLane(rest);
    startLane  = hiLane(sel_i);

    case (state_q)
      S_IDLE: begin
        if (ce_i && (sel_i != 4'b0000)) begin
          we_d       = we_i;
          addr_d     = addr_i[SRAM_AW-1:2];
          sel_d      = sel_i;
          wdata_d    = data_i;
          lane_d     = startLane;
          cnt_d      = 3'd0;
          asm_d      = 32'h0;
          sramAddr_d = {addr_i[SRAM_AW-1:2], ~startLane};
          ceN_d      = 1'b0;
          if (we_i) begin
            state_d = S_WS;
            dqOe_d  = 1'b1;
            dqOut_d = laneByte(data_i, startLane);
          end else begin
            state_d = S_RD;
            oeN_d   = 1'b0;
          end
        end
      end

      S_RD: begin
        ceN_d = 1'b0;
        oeN_d = 1'b0;
        if (cnt_q == RD_LAST) begin
          asm_d[{lane_q, 3'b000} +: 8] = sram_dq_i;
          cnt_d = 3'd0;
          sel_d = rest;
          if (rest != 4'b0000) begin
            lane_d     = nextLane;
            sramAddr_d = {addr_q, ~nextLane};
          end else begin
            state_d   = S_DONE;
            ceN_d     = 1'b1;
            oeN_d     = 1'b1;
            dataOut_d = asm_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_WS: begin
        state_d = S_WP;
        ceN_d   = 1'b0;
        weN_d   = 1'b0;
        dqOe_d  = 1'b1;
      end

      S_WP: begin
        sel_d = rest;
        if (rest != 4'b0000) begin
          state_d    = S_WS;
          lane_d     = nextLane;
          sramAddr_d = {addr_q, ~nextLane};
          dqOut_d    = laneByte(wdata_q, nextLane);
          ceN_d      = 1'b0;
          dqOe_d     = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= 4'b0000;
      wdata_q    <= 32'h0;
      lane_q     <= 2'd0;
      cnt_q      <= 3'd0;
      asm_q      <= 32'h0;
      sramAddr_q <= '0;
      dqOut_q    <= 8'h00;
      dqOe_q     <= 1'b0;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      dataOut_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      sramAddr_q <= sramAddr_d;
      dqOut_q    <= dqOut_d;
      dqOe_q     <= dqOe_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      dataOut_q  <= dataOut_d;
    end
  end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Data-memory responder for the MEM stage's RAM request port (`ce`, `we`, `addr`, `sel`, `data`).
- Serves each 32-bit big-endian, byte-lane-selected request on an external 8-bit asynchronous SRAM, one byte per access.
- Holds the pipeline with `stallreq_o` until the word is assembled or written.
- Sits between the MEM stage and the board SRAM pins, in place of the on-chip data RAM.

## Interface
Parameters:
- `SRAM_AW`, 20: SRAM byte-address width.
- `RD_WAIT`, 1: extra wait cycles per byte read (0..7).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ce_i` in 1: request valid from MEM stage.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address; bits [1:0] ignored (lanes come from `sel_i`).
- `sel_i` in 4: lane enables; bit3 = data[31:24] = offset 0, bit0 = data[7:0] = offset 3.
- `data_i` in 32: write data.
- `data_o` out 32: read data; unselected lanes are 0.
- `stallreq_o` out 1: pipeline stall request.
- `sram_addr_o` out SRAM_AW: SRAM byte address.
- `sram_dq_o` out 8: write byte.
- `sram_dq_oe_o` out 1: drive DQ pins.
- `sram_dq_i` in 8: read byte.
- `sram_ce_n_o` out 1: SRAM chip enable, active-low.
- `sram_oe_n_o` out 1: SRAM output enable, active-low.
- `sram_we_n_o` out 1: SRAM write enable, active-low.

## Operation
States: IDLE, RD, WS (write setup), WP (write pulse), DONE.

IDLE:
- `ce_i`=1 and `sel_i`≠0: latch `we_i`, `addr_i[SRAM_AW-1:2]`, `sel_i`, `data_i`. Lane = highest set `sel` bit. Go to RD (read) or WS (write).
- `ce_i`=1 and `sel_i`=0: no access, no stall, `data_o`=0.

Lanes and addressing:
- Lane L maps to offset 3−L.
- `sram_addr_o` = {latched addr[SRAM_AW-1:2], 3−L}.
- Lanes are visited high to low; clear `sel` bits are skipped with no cycle spent.

RD:
- `ce_n`=0, `oe_n`=0, `we_n`=1, `dq_oe`=0, held for RD_WAIT+1 cycles (cycle counter).
- On the last cycle, sample `sram_dq_i` into byte lane L of the assembly register.
- Then advance to the next selected lane (stay in RD), or go to DONE.

WS: `ce_n`=0, `we_n`=1, `dq_oe`=1, `sram_dq_o` = data byte of lane L. Go to WP.

WP:
- Same address and data as WS, with `we_n`=0.
- Then WS for the next selected lane, or DONE.
- Address and data are stable for one cycle before and during the `we_n` low pulse.

DONE:
- All SRAM controls inactive.
- `data_o` = assembled word (zeros in unselected lanes; 0 for writes).
- Go to IDLE.

Output rules:
- `stallreq_o` = `ce_i` && `sel_i`≠0 && state≠DONE. Combinational, so the stall is raised in the same cycle the request appears.
- `data_o` is registered and valid in DONE.
- The assembly register clears on each new accepted request.

Other behaviour:
- The latched request is used for the whole access. Changes on `*_i` during RD/WS/WP are ignored.
- A request still present after DONE (pipeline stalled elsewhere) is re-executed. This is idempotent for loads and stores.

## Timing
- All SRAM-side outputs are registered.
- Reset values:
  - state = IDLE
  - `sram_ce_n_o` = `sram_oe_n_o` = `sram_we_n_o` = 1
  - `sram_dq_oe_o` = 0, `sram_dq_o` = 0, `sram_addr_o` = 0
  - `data_o` = 0
  - `stallreq_o` follows its equation with state IDLE.
- Cycles are counted from the request's first cycle (cycle 0, in IDLE).
  - Read of n selected bytes: DONE at cycle 1 + n·(RD_WAIT+1).
  - Write of n selected bytes: DONE at cycle 1 + 2n.
- `stallreq_o`=1 on cycles 0..DONE−1 and 0 in DONE, so the pipeline advances at the DONE edge.
- Back-to-back: a new request is accepted on the cycle after DONE.
- `rst` mid-access: the next edge forces reset values. An in-progress byte write may be truncated; no further bytes are written.

## Test plan
- Reset, then idle → all SRAM controls high, `dq_oe`=0, `data_o`=0, `stallreq_o`=0.
- SRAM preloaded 0x100..0x103 = 11 22 33 44; LW (`ce`=1, `we`=0, addr 0x100, `sel`=1111), RD_WAIT=1 → addresses 0x100..0x103 read in order, `stallreq_o` high on cycles 0–8, DONE at cycle 9 with `data_o`=0x11223344.
- SB addr 0x202, `sel`=0010, `data_i`=0xAAAAAAAA → single WS/WP at address 0x202 with dq=0xAA, `we_n` low for exactly one cycle, DONE at cycle 3; neighbouring bytes unchanged.
- SWR-style `sel`=1110, `data_i`=0xDEADBE00 at 0x300 → writes DE, AD, BE to 0x300..0x302, skips 0x303, DONE at cycle 7.
- `sel`=0000 with `ce`=1 → no SRAM activity, `stallreq_o`=0; `rst` pulsed during byte 2 of an SW → controls inactive on the next cycle, byte 3 not written, state IDLE.
